// File: rtl/urx_frame.sv
// 8N1 UART receiver, 16x oversampled, one-cycle valid / frame_err strobes.
// Ports: clk, rst_n, rx_in -> data_out[7:0], valid, frame_err, busy.
module urx_frame #(
   parameter int CLK_DIV = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_in,
   output logic [7:0] data_out,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] START = 3'd1;
   localparam logic [2:0] DATA  = 3'd2;
   localparam logic [2:0] STOP  = 3'd3;
   localparam logic [2:0] BRK   = 3'd4;

   logic [2:0]    state;
   logic          s1, rxs, rxd;
   logic [1:0]    wu;
   logic          armed;
   logic [PW-1:0] pc;
   logic [3:0]    tc;
   logic [2:0]    bi;
   logic [7:0]    sh;
   logic          tick, samp, fe;

   assign tick = (pc == PW'(CLK_DIV - 1));
   assign samp = tick & (tc == 4'd7);
   // armed blocks the fake edge seen when the reset-high sync chain
   // first meets a line that is already low.
   assign fe   = rxd & ~rxs & armed;
   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1        <= 1'b1;
         rxs       <= 1'b1;
         rxd       <= 1'b1;
         wu        <= 2'b00;
         armed     <= 1'b0;
         pc        <= '0;
         tc        <= 4'd0;
         state     <= IDLE;
         bi        <= 3'd0;
         sh        <= 8'h00;
         data_out  <= 8'h00;
         valid     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         s1        <= rx_in;
         rxs       <= s1;
         rxd       <= rxs;
         wu        <= {wu[0], 1'b1};
         if (wu[1] & rxs)
            armed <= 1'b1;
         valid     <= 1'b0;
         frame_err <= 1'b0;

         // The fe cycle counts as prescaler phase 0, so mid-bit
         // samples land 8*CLK_DIV-1 cycles after the edge.
         if (state == IDLE) begin
            if (fe) begin
               pc <= PW'(1);
               tc <= 4'd0;
            end
         end else begin
            pc <= tick ? '0 : pc + 1'b1;
            if (tick)
               tc <= tc + 4'd1;
         end

         unique case (state)
            IDLE: begin
               if (fe)
                  state <= START;
            end
            START: begin
               if (samp) begin
                  if (rxs) begin
                     state <= IDLE;
                  end else begin
                     state <= DATA;
                     bi    <= 3'd0;
                  end
               end
            end
            DATA: begin
               if (samp) begin
                  sh <= {rxs, sh[7:1]};
                  bi <= bi + 3'd1;
                  if (bi == 3'd7)
                     state <= STOP;
               end
            end
            STOP: begin
               if (samp) begin
                  if (rxs) begin
                     data_out <= sh;
                     valid    <= 1'b1;
                     state    <= IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= BRK;
                  end
               end
            end
            BRK: begin
               if (rxs)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
